// File: rtl/serial_adder.sv
// Serial a+b+cin adder, BITS_PER_CYCLE bits per clock LSB first; result valid WIDTH/BITS_PER_CYCLE edges after accept.
// Result held under out_ready backpressure, no new operands until handoff; ovf port only with SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int NSTEP = WIDTH / BPC;
  localparam int CNTW  = $clog2(NSTEP) + 1;

  generate
    if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_param
      $error("serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_sum;
  logic              r_carry;
  logic              r_cout;
  logic [CNTW-1:0]   r_cnt;
  logic              w_accept;
  logic              w_step;
  logic              w_last;
  logic [BPC-1:0]    w_slice;
  logic [BPC:0]      w_c;
  logic [WIDTH+BPC-1:0] w_acc_cat;
  logic [WIDTH-1:0]  w_acc_nxt;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_step   = (r_state == S_RUN);
  assign w_last   = (r_cnt == CNTW'(NSTEP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ripple chain of full-adder cells across the slice, fed by the carry flop.
  always_comb begin
    w_c     = '0;
    w_slice = '0;
    w_c[0]  = r_carry;
    for (int i = 0; i < BPC; i++) begin
      w_slice[i] = r_a[i] ^ r_b[i] ^ w_c[i];
      w_c[i+1]   = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
    end
  end

  assign w_acc_cat = {w_slice, r_acc};
  assign w_acc_nxt = WIDTH'(w_acc_cat >> BPC);

`ifdef SERIAL_ADDER_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (w_step && w_last) begin
      r_ovf <= (r_a_msb == r_b_msb) && (w_acc_nxt[WIDTH-1] != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

  // Partial sums build in r_acc so the visible sum only changes on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_acc   <= '0;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= r_a >> BPC;
      r_b     <= r_b >> BPC;
      r_acc   <= w_acc_nxt;
      r_carry <= w_c[BPC];
      r_cnt   <= r_cnt + CNTW'(1);
      if (w_last) begin
        r_sum  <= w_acc_nxt;
        r_cout <= w_c[BPC];
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Bench: a 1-bit-per-cycle and a 4-bit-per-cycle adder share one stimulus stream and are
// checked every cycle against an arithmetic model, plus hand-computed literal expectations.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;

  logic       in_ready0, in_ready1, out_valid0, out_valid1, cout0, cout1;
  logic [7:0] sum0, sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf0, ovf1;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid0), .out_ready(out_ready),
    .sum(sum0), .cout(cout0)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf0)
`endif
  );

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a result is a+b+cin sampled at acceptance, visible NSTEP edges later,
  // held until handed off; the sum/cout outputs keep the last result otherwise.
  int         m_left[2] = '{0, 0};
  bit         m_vld[2]  = '{0, 0};
  logic [7:0] m_sum[2]  = '{8'h00, 8'h00};
  logic [7:0] m_rsum[2] = '{8'h00, 8'h00};
  logic       m_cout[2] = '{1'b0, 1'b0};
  logic       m_rcout[2] = '{1'b0, 1'b0};
  logic       m_ovf[2]  = '{1'b0, 1'b0};
  logic       m_rovf[2] = '{1'b0, 1'b0};
  logic [8:0] m_t;
  logic       act_rdy, act_vld, act_cout, act_ovf;
  logic [7:0] act_sum;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_left[k] = 0; m_vld[k] = 0; m_sum[k] = 8'h00; m_cout[k] = 1'b0; m_ovf[k] = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      act_rdy  = (k == 0) ? in_ready0  : in_ready1;
      act_vld  = (k == 0) ? out_valid0 : out_valid1;
      act_sum  = (k == 0) ? sum0       : sum1;
      act_cout = (k == 0) ? cout0      : cout1;
      chk($sformatf("in_ready[%0d]", k), 32'(act_rdy), 32'(!m_vld[k] && m_left[k] == 0));
      chk($sformatf("out_valid[%0d]", k), 32'(act_vld), 32'(m_vld[k]));
      chk($sformatf("sum[%0d]", k), 32'(act_sum), 32'(m_sum[k]));
      chk($sformatf("cout[%0d]", k), 32'(act_cout), 32'(m_cout[k]));
`ifdef SERIAL_ADDER_OVF_EN
      act_ovf = (k == 0) ? ovf0 : ovf1;
      chk($sformatf("ovf[%0d]", k), 32'(act_ovf), 32'(m_ovf[k]));
`else
      act_ovf = 1'b0;
`endif
    end
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (m_vld[k]) begin
          if (out_ready) m_vld[k] = 0;
        end else if (m_left[k] > 0) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_vld[k] = 1; m_sum[k] = m_rsum[k]; m_cout[k] = m_rcout[k]; m_ovf[k] = m_rovf[k];
          end
        end else if (in_valid) begin
          m_left[k]  = (k == 0) ? 8 : 2;
          m_t        = {1'b0, a} + {1'b0, b} + {8'h00, cin};
          m_rsum[k]  = m_t[7:0];
          m_rcout[k] = m_t[8];
          m_rovf[k]  = (a[7] == b[7]) && (m_t[7] != a[7]);
        end
      end
    end
  end

  task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                    output int lat0, output int lat1);
    int n;
    n = 0;
    while (!(in_ready0 && in_ready1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idle", 32'(in_ready0 && in_ready1), 32'd1);
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat0 = 0; lat1 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid1 && lat1 == 0) lat1 = i;
      if (out_valid0) begin
        lat0 = i;
        break;
      end
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int l0, l1, n1, seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready0), 32'd1);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_sum", 32'(sum0), 32'd0);
    rst_n = 1'b1;

    op(8'h0F, 8'h01, 1'b0, l0, l1);
    chk("t1_latency", 32'(l0), 32'd8);
    chk("t1_latency_bpc4", 32'(l1), 32'd2);
    chk("t1_sum", 32'(sum0), 32'h10);
    chk("t1_cout", 32'(cout0), 32'd0);
    chk("t1_sum_bpc4", 32'(sum1), 32'h10);
    handoff();

    op(8'hFF, 8'h01, 1'b0, l0, l1);
    chk("t2_sum", 32'(sum0), 32'h00);
    chk("t2_cout", 32'(cout0), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("t2_ovf", 32'(ovf0), 32'd0);
`endif
    handoff();

    op(8'h7F, 8'h01, 1'b0, l0, l1);
    chk("t3_sum", 32'(sum0), 32'h80);
    chk("t3_cout", 32'(cout0), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("t3_ovf", 32'(ovf0), 32'd1);
`endif
    handoff();

    op(8'hA5, 8'h5A, 1'b1, l0, l1);
    chk("t6_latency_bpc4", 32'(l1), 32'd2);
    chk("t6_sum_bpc4", 32'(sum1), 32'h00);
    chk("t6_cout_bpc4", 32'(cout1), 32'd1);
    handoff();

    // Backpressure: result must hold and operand pulses must be ignored.
    op(8'h3C, 8'h4B, 1'b1, l0, l1);
    chk("t4_sum", 32'(sum0), 32'h88);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = 8'(i * 17 + 1);
      @(posedge clk); #1;
      chk("t4_hold_valid", 32'(out_valid0), 32'd1);
      chk("t4_hold_sum", 32'(sum0), 32'h88);
      chk("t4_hold_cout", 32'(cout0), 32'd0);
      chk("t4_in_ready", 32'(in_ready0), 32'd0);
    end
    a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t4_no_accept_in_done", 32'(in_ready0), 32'd1);
    chk("t4_handed_off", 32'(out_valid0), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_accept_next", 32'(in_ready0), 32'd0);
    seen = 0;
    while (!out_valid0 && seen < 20) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("t4_second_sum", 32'(sum0), 32'h33);
    handoff();

    // Reset three edges into RUN discards the transaction.
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid0), 32'd0);
    chk("t5_sum", 32'(sum0), 32'd0);
    chk("t5_in_ready", 32'(in_ready0), 32'd1);
    chk("t5_out_valid_bpc4", 32'(out_valid1), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid0 || out_valid1) seen = 1;
    end
    chk("t5_no_result", 32'(seen), 32'd0);

    // Back-to-back random traffic, consumer always ready.
    out_ready = 1'b1;
    in_valid = 1'b1;
    n1 = 0;
    for (int cyc = 0; cyc < 2000 && n1 < 200; cyc++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      if (out_valid1) n1++;
    end
    chk("t6_random_count", 32'(n1), 32'd200);
    in_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
